// File: rtl/udp_hdr_tx_pkg.sv
// Shared definitions for the UDP header transmitter: FSM states, header
// length and the header byte serialiser.
package udp_hdr_tx_pkg;

  localparam int          UDP_HDR_LEN   = 8;
  localparam logic [15:0] UDP_HDR_LEN16 = 16'(UDP_HDR_LEN);

  typedef enum logic [1:0] {
    ST_IDLE          = 2'd0,
    ST_WRITE_HEADER  = 2'd1,
    ST_WRITE_PAYLOAD = 2'd2,
    ST_DROP_PAYLOAD  = 2'd3
  } udp_tx_state_t;

  // Byte idx of the 8-byte UDP header, big-endian field order.
  function automatic logic [7:0] udp_hdr_byte(
    input logic [2:0]  idx,
    input logic [15:0] sport,
    input logic [15:0] dport,
    input logic [15:0] len,
    input logic [15:0] csum
  );
    logic [7:0] b;
    case (idx)
      3'd0:    b = sport[15:8];
      3'd1:    b = sport[7:0];
      3'd2:    b = dport[15:8];
      3'd3:    b = dport[7:0];
      3'd4:    b = len[15:8];
      3'd5:    b = len[7:0];
      3'd6:    b = csum[15:8];
      default: b = csum[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/axis_skid_reg8.sv
// Two-entry AXI-Stream register slice for an 8-bit stream with tlast/tuser.
// The upstream ready is a register, so it never depends combinationally on
// the downstream ready; the second entry absorbs the beat in flight.
module axis_skid_reg8 (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] i_s_tdata,
  input  logic       i_s_tvalid,
  output logic       o_s_tready,
  input  logic       i_s_tlast,
  input  logic       i_s_tuser,
  output logic [7:0] o_m_tdata,
  output logic       o_m_tvalid,
  input  logic       i_m_tready,
  output logic       o_m_tlast,
  output logic       o_m_tuser
);

  logic [9:0] r_m_data;
  logic [9:0] r_t_data;
  logic       r_m_valid;
  logic       r_t_valid;
  logic       r_s_ready;

  logic [9:0] w_in_data;
  logic       w_in_xfer;
  logic       w_s_ready_next;
  logic       w_m_valid_next;
  logic       w_t_valid_next;
  logic       w_ld_in_m;
  logic       w_ld_in_t;
  logic       w_ld_t_m;

  assign w_in_data = {i_s_tlast, i_s_tuser, i_s_tdata};
  assign w_in_xfer = i_s_tvalid && r_s_ready;

  // Accept next cycle if the output drains, or if both entries stay non-full.
  assign w_s_ready_next = i_m_tready || (!r_t_valid && (!r_m_valid || !w_in_xfer));

  // Route the incoming beat to the output or skid entry, or refill from skid.
  always_comb begin
    w_m_valid_next = r_m_valid;
    w_t_valid_next = r_t_valid;
    w_ld_in_m      = 1'b0;
    w_ld_in_t      = 1'b0;
    w_ld_t_m       = 1'b0;
    if (r_s_ready) begin
      if (i_m_tready || !r_m_valid) begin
        w_m_valid_next = i_s_tvalid;
        w_ld_in_m      = 1'b1;
      end else begin
        w_t_valid_next = i_s_tvalid;
        w_ld_in_t      = 1'b1;
      end
    end else if (i_m_tready) begin
      w_m_valid_next = r_t_valid;
      w_t_valid_next = 1'b0;
      w_ld_t_m       = 1'b1;
    end
  end

  // Control state: valids and registered ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s_ready <= 1'b0;
      r_m_valid <= 1'b0;
      r_t_valid <= 1'b0;
    end else begin
      r_s_ready <= w_s_ready_next;
      r_m_valid <= w_m_valid_next;
      r_t_valid <= w_t_valid_next;
    end
  end

  // Data entries, no reset needed.
  always_ff @(posedge clk) begin
    if (w_ld_in_m) begin
      r_m_data <= w_in_data;
    end else if (w_ld_t_m) begin
      r_m_data <= r_t_data;
    end
    if (w_ld_in_t) begin
      r_t_data <= w_in_data;
    end
  end

  assign o_s_tready = r_s_ready;
  assign o_m_tvalid = r_m_valid;
  assign o_m_tdata  = r_m_data[7:0];
  assign o_m_tuser  = r_m_data[8];
  assign o_m_tlast  = r_m_data[9];

endmodule

// File: rtl/udp_hdr_tx.sv
// UDP header transmitter: latches a UDP/IP/Ethernet header, forwards the
// IP/Ethernet fields on a header handshake and prepends the 8 UDP header
// bytes to the UDP payload on the outgoing IP payload stream. The payload
// is trimmed or terminated to match the declared UDP length.
module udp_hdr_tx
  import udp_hdr_tx_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        s_udp_hdr_valid,
  output logic        s_udp_hdr_ready,
  input  logic [47:0] s_eth_dest_mac,
  input  logic [47:0] s_eth_src_mac,
  input  logic [15:0] s_eth_type,
  input  logic [3:0]  s_ip_version,
  input  logic [3:0]  s_ip_ihl,
  input  logic [5:0]  s_ip_dscp,
  input  logic [1:0]  s_ip_ecn,
  input  logic [15:0] s_ip_length,
  input  logic [15:0] s_ip_identification,
  input  logic [2:0]  s_ip_flags,
  input  logic [12:0] s_ip_fragment_offset,
  input  logic [7:0]  s_ip_ttl,
  input  logic [7:0]  s_ip_protocol,
  input  logic [15:0] s_ip_header_checksum,
  input  logic [31:0] s_ip_source_ip,
  input  logic [31:0] s_ip_dest_ip,
  input  logic [15:0] s_udp_source_port,
  input  logic [15:0] s_udp_dest_port,
  input  logic [15:0] s_udp_length,
  input  logic [15:0] s_udp_checksum,
  input  logic [7:0]  s_udp_payload_axis_tdata,
  input  logic        s_udp_payload_axis_tvalid,
  output logic        s_udp_payload_axis_tready,
  input  logic        s_udp_payload_axis_tlast,
  input  logic        s_udp_payload_axis_tuser,
  output logic        m_ip_hdr_valid,
  input  logic        m_ip_hdr_ready,
  output logic [47:0] m_eth_dest_mac,
  output logic [47:0] m_eth_src_mac,
  output logic [15:0] m_eth_type,
  output logic [3:0]  m_ip_version,
  output logic [3:0]  m_ip_ihl,
  output logic [5:0]  m_ip_dscp,
  output logic [1:0]  m_ip_ecn,
  output logic [15:0] m_ip_length,
  output logic [15:0] m_ip_identification,
  output logic [2:0]  m_ip_flags,
  output logic [12:0] m_ip_fragment_offset,
  output logic [7:0]  m_ip_ttl,
  output logic [7:0]  m_ip_protocol,
  output logic [15:0] m_ip_header_checksum,
  output logic [31:0] m_ip_source_ip,
  output logic [31:0] m_ip_dest_ip,
  output logic [7:0]  m_ip_payload_axis_tdata,
  output logic        m_ip_payload_axis_tvalid,
  input  logic        m_ip_payload_axis_tready,
  output logic        m_ip_payload_axis_tlast,
  output logic        m_ip_payload_axis_tuser,
  output logic        busy,
  output logic        error_payload_early_termination
);

  udp_tx_state_t r_state;
  udp_tx_state_t w_state_next;
  logic [15:0]   r_cnt;
  logic [15:0]   w_cnt_next;
  logic          r_hdr_valid;
  logic          w_hdr_valid_next;
  logic          r_hdr_ready;
  logic          r_err;
  logic          w_err_next;
  logic          w_store_hdr;
  logic          w_pl_tready;

  logic [7:0]    w_sk_tdata;
  logic          w_sk_tvalid;
  logic          w_sk_tlast;
  logic          w_sk_tuser;
  logic          w_sk_ready;

  logic [47:0]   r_eth_dest_mac;
  logic [47:0]   r_eth_src_mac;
  logic [15:0]   r_eth_type;
  logic [3:0]    r_ip_version;
  logic [3:0]    r_ip_ihl;
  logic [5:0]    r_ip_dscp;
  logic [1:0]    r_ip_ecn;
  logic [15:0]   r_ip_length;
  logic [15:0]   r_ip_identification;
  logic [2:0]    r_ip_flags;
  logic [12:0]   r_ip_fragment_offset;
  logic [7:0]    r_ip_ttl;
  logic [7:0]    r_ip_protocol;
  logic [15:0]   r_ip_header_checksum;
  logic [31:0]   r_ip_source_ip;
  logic [31:0]   r_ip_dest_ip;
  logic [15:0]   r_udp_source_port;
  logic [15:0]   r_udp_dest_port;
  logic [15:0]   r_udp_length;
  logic [15:0]   r_udp_checksum;

  // Next-state, counter and stream-beat generation for the frame FSM.
  always_comb begin
    w_state_next     = r_state;
    w_cnt_next       = r_cnt;
    w_hdr_valid_next = r_hdr_valid && !m_ip_hdr_ready;
    w_err_next       = 1'b0;
    w_store_hdr      = 1'b0;
    w_pl_tready      = 1'b0;
    w_sk_tvalid      = 1'b0;
    w_sk_tdata       = 8'h00;
    w_sk_tlast       = 1'b0;
    w_sk_tuser       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (s_udp_hdr_valid && r_hdr_ready) begin
          w_store_hdr      = 1'b1;
          w_hdr_valid_next = 1'b1;
          w_cnt_next       = 16'd0;
          w_state_next     = ST_WRITE_HEADER;
        end
      end
      ST_WRITE_HEADER: begin
        if (w_sk_ready) begin
          w_sk_tvalid = 1'b1;
          w_sk_tdata  = udp_hdr_byte(r_cnt[2:0], r_udp_source_port, r_udp_dest_port,
                                     r_udp_length, r_udp_checksum);
          w_cnt_next  = r_cnt + 16'd1;
          if (r_cnt == UDP_HDR_LEN16 - 16'd1) begin
            if (r_udp_length <= UDP_HDR_LEN16) begin
              // No room for payload: close the frame on the last header byte.
              w_sk_tlast   = 1'b1;
              w_cnt_next   = 16'd0;
              w_state_next = ST_DROP_PAYLOAD;
            end else begin
              w_cnt_next   = r_udp_length - UDP_HDR_LEN16;
              w_state_next = ST_WRITE_PAYLOAD;
            end
          end
        end
      end
      ST_WRITE_PAYLOAD: begin
        w_pl_tready = w_sk_ready;
        if (s_udp_payload_axis_tvalid && w_sk_ready) begin
          w_sk_tvalid = 1'b1;
          w_sk_tdata  = s_udp_payload_axis_tdata;
          w_sk_tuser  = s_udp_payload_axis_tuser;
          w_cnt_next  = r_cnt - 16'd1;
          if (s_udp_payload_axis_tlast) begin
            w_sk_tlast   = 1'b1;
            w_cnt_next   = 16'd0;
            w_state_next = ST_IDLE;
            if (r_cnt != 16'd1) begin
              // Payload shorter than declared: flag the frame as bad.
              w_sk_tuser = 1'b1;
              w_err_next = 1'b1;
            end
          end else if (r_cnt == 16'd1) begin
            // Declared length reached: end the frame, discard the remainder.
            w_sk_tlast   = 1'b1;
            w_cnt_next   = 16'd0;
            w_state_next = ST_DROP_PAYLOAD;
          end
        end
      end
      ST_DROP_PAYLOAD: begin
        w_pl_tready = 1'b1;
        if (s_udp_payload_axis_tvalid && s_udp_payload_axis_tlast) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // FSM state register and control flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 16'd0;
      r_hdr_valid <= 1'b0;
      r_hdr_ready <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_hdr_valid <= w_hdr_valid_next;
      r_hdr_ready <= (w_state_next == ST_IDLE) && !w_hdr_valid_next;
      r_err       <= w_err_next;
    end
  end

  // Header field capture on accept; held stable until the next accept.
  always_ff @(posedge clk) begin
    if (w_store_hdr) begin
      r_eth_dest_mac       <= s_eth_dest_mac;
      r_eth_src_mac        <= s_eth_src_mac;
      r_eth_type           <= s_eth_type;
      r_ip_version         <= s_ip_version;
      r_ip_ihl             <= s_ip_ihl;
      r_ip_dscp            <= s_ip_dscp;
      r_ip_ecn             <= s_ip_ecn;
      r_ip_length          <= s_ip_length;
      r_ip_identification  <= s_ip_identification;
      r_ip_flags           <= s_ip_flags;
      r_ip_fragment_offset <= s_ip_fragment_offset;
      r_ip_ttl             <= s_ip_ttl;
      r_ip_protocol        <= s_ip_protocol;
      r_ip_header_checksum <= s_ip_header_checksum;
      r_ip_source_ip       <= s_ip_source_ip;
      r_ip_dest_ip         <= s_ip_dest_ip;
      r_udp_source_port    <= s_udp_source_port;
      r_udp_dest_port      <= s_udp_dest_port;
      r_udp_length         <= s_udp_length;
      r_udp_checksum       <= s_udp_checksum;
    end
  end

  axis_skid_reg8 u_skid (
    .clk        (clk),
    .rst        (rst),
    .i_s_tdata  (w_sk_tdata),
    .i_s_tvalid (w_sk_tvalid),
    .o_s_tready (w_sk_ready),
    .i_s_tlast  (w_sk_tlast),
    .i_s_tuser  (w_sk_tuser),
    .o_m_tdata  (m_ip_payload_axis_tdata),
    .o_m_tvalid (m_ip_payload_axis_tvalid),
    .i_m_tready (m_ip_payload_axis_tready),
    .o_m_tlast  (m_ip_payload_axis_tlast),
    .o_m_tuser  (m_ip_payload_axis_tuser)
  );

  assign s_udp_hdr_ready                 = r_hdr_ready;
  assign s_udp_payload_axis_tready       = w_pl_tready;
  assign busy                            = (r_state != ST_IDLE);
  assign error_payload_early_termination = r_err;
  assign m_ip_hdr_valid                  = r_hdr_valid;
  assign m_eth_dest_mac                  = r_eth_dest_mac;
  assign m_eth_src_mac                   = r_eth_src_mac;
  assign m_eth_type                      = r_eth_type;
  assign m_ip_version                    = r_ip_version;
  assign m_ip_ihl                        = r_ip_ihl;
  assign m_ip_dscp                       = r_ip_dscp;
  assign m_ip_ecn                        = r_ip_ecn;
  assign m_ip_length                     = r_ip_length;
  assign m_ip_identification             = r_ip_identification;
  assign m_ip_flags                      = r_ip_flags;
  assign m_ip_fragment_offset            = r_ip_fragment_offset;
  assign m_ip_ttl                        = r_ip_ttl;
  assign m_ip_protocol                   = r_ip_protocol;
  assign m_ip_header_checksum            = r_ip_header_checksum;
  assign m_ip_source_ip                  = r_ip_source_ip;
  assign m_ip_dest_ip                    = r_ip_dest_ip;

endmodule

// File: tb/tb_udp_hdr_tx.sv
// Directed bench for udp_hdr_tx: frame formatting, early/long payload
// handling, short-length drop, back-to-back frames under random backpressure
// and mid-frame reset.
module tb_udp_hdr_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_udp_hdr_valid = 1'b0;
  logic        s_udp_hdr_ready;
  logic [47:0] s_eth_dest_mac = 48'h0211_2233_4455;
  logic [47:0] s_eth_src_mac = 48'h0266_7788_99AA;
  logic [15:0] s_eth_type = 16'h0800;
  logic [3:0]  s_ip_version = 4'd4;
  logic [3:0]  s_ip_ihl = 4'd5;
  logic [5:0]  s_ip_dscp = 6'd0;
  logic [1:0]  s_ip_ecn = 2'd0;
  logic [15:0] s_ip_length = 16'd32;
  logic [15:0] s_ip_identification = 16'h0001;
  logic [2:0]  s_ip_flags = 3'b010;
  logic [12:0] s_ip_fragment_offset = 13'd0;
  logic [7:0]  s_ip_ttl = 8'd64;
  logic [7:0]  s_ip_protocol = 8'h11;
  logic [15:0] s_ip_header_checksum = 16'h0000;
  logic [31:0] s_ip_source_ip = 32'hC0A8_0001;
  logic [31:0] s_ip_dest_ip = 32'hC0A8_0002;
  logic [15:0] s_udp_source_port = 16'h0;
  logic [15:0] s_udp_dest_port = 16'h0;
  logic [15:0] s_udp_length = 16'h0;
  logic [15:0] s_udp_checksum = 16'h0;
  logic [7:0]  s_udp_payload_axis_tdata = 8'h0;
  logic        s_udp_payload_axis_tvalid = 1'b0;
  logic        s_udp_payload_axis_tready;
  logic        s_udp_payload_axis_tlast = 1'b0;
  logic        s_udp_payload_axis_tuser = 1'b0;
  logic        m_ip_hdr_valid;
  logic        m_ip_hdr_ready = 1'b1;
  logic [47:0] m_eth_dest_mac;
  logic [47:0] m_eth_src_mac;
  logic [15:0] m_eth_type;
  logic [3:0]  m_ip_version;
  logic [3:0]  m_ip_ihl;
  logic [5:0]  m_ip_dscp;
  logic [1:0]  m_ip_ecn;
  logic [15:0] m_ip_length;
  logic [15:0] m_ip_identification;
  logic [2:0]  m_ip_flags;
  logic [12:0] m_ip_fragment_offset;
  logic [7:0]  m_ip_ttl;
  logic [7:0]  m_ip_protocol;
  logic [15:0] m_ip_header_checksum;
  logic [31:0] m_ip_source_ip;
  logic [31:0] m_ip_dest_ip;
  logic [7:0]  m_ip_payload_axis_tdata;
  logic        m_ip_payload_axis_tvalid;
  logic        m_ip_payload_axis_tready = 1'b1;
  logic        m_ip_payload_axis_tlast;
  logic        m_ip_payload_axis_tuser;
  logic        busy;
  logic        error_payload_early_termination;

  udp_hdr_tx dut (
    .clk                             (clk),
    .rst                             (rst),
    .s_udp_hdr_valid                 (s_udp_hdr_valid),
    .s_udp_hdr_ready                 (s_udp_hdr_ready),
    .s_eth_dest_mac                  (s_eth_dest_mac),
    .s_eth_src_mac                   (s_eth_src_mac),
    .s_eth_type                      (s_eth_type),
    .s_ip_version                    (s_ip_version),
    .s_ip_ihl                        (s_ip_ihl),
    .s_ip_dscp                       (s_ip_dscp),
    .s_ip_ecn                        (s_ip_ecn),
    .s_ip_length                     (s_ip_length),
    .s_ip_identification             (s_ip_identification),
    .s_ip_flags                      (s_ip_flags),
    .s_ip_fragment_offset            (s_ip_fragment_offset),
    .s_ip_ttl                        (s_ip_ttl),
    .s_ip_protocol                   (s_ip_protocol),
    .s_ip_header_checksum            (s_ip_header_checksum),
    .s_ip_source_ip                  (s_ip_source_ip),
    .s_ip_dest_ip                    (s_ip_dest_ip),
    .s_udp_source_port               (s_udp_source_port),
    .s_udp_dest_port                 (s_udp_dest_port),
    .s_udp_length                    (s_udp_length),
    .s_udp_checksum                  (s_udp_checksum),
    .s_udp_payload_axis_tdata        (s_udp_payload_axis_tdata),
    .s_udp_payload_axis_tvalid       (s_udp_payload_axis_tvalid),
    .s_udp_payload_axis_tready       (s_udp_payload_axis_tready),
    .s_udp_payload_axis_tlast        (s_udp_payload_axis_tlast),
    .s_udp_payload_axis_tuser        (s_udp_payload_axis_tuser),
    .m_ip_hdr_valid                  (m_ip_hdr_valid),
    .m_ip_hdr_ready                  (m_ip_hdr_ready),
    .m_eth_dest_mac                  (m_eth_dest_mac),
    .m_eth_src_mac                   (m_eth_src_mac),
    .m_eth_type                      (m_eth_type),
    .m_ip_version                    (m_ip_version),
    .m_ip_ihl                        (m_ip_ihl),
    .m_ip_dscp                       (m_ip_dscp),
    .m_ip_ecn                        (m_ip_ecn),
    .m_ip_length                     (m_ip_length),
    .m_ip_identification             (m_ip_identification),
    .m_ip_flags                      (m_ip_flags),
    .m_ip_fragment_offset            (m_ip_fragment_offset),
    .m_ip_ttl                        (m_ip_ttl),
    .m_ip_protocol                   (m_ip_protocol),
    .m_ip_header_checksum            (m_ip_header_checksum),
    .m_ip_source_ip                  (m_ip_source_ip),
    .m_ip_dest_ip                    (m_ip_dest_ip),
    .m_ip_payload_axis_tdata         (m_ip_payload_axis_tdata),
    .m_ip_payload_axis_tvalid        (m_ip_payload_axis_tvalid),
    .m_ip_payload_axis_tready        (m_ip_payload_axis_tready),
    .m_ip_payload_axis_tlast         (m_ip_payload_axis_tlast),
    .m_ip_payload_axis_tuser         (m_ip_payload_axis_tuser),
    .busy                            (busy),
    .error_payload_early_termination (error_payload_early_termination)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  logic rnd_en = 1'b0;

  // Monitor state: captured output beats {tlast,tuser,tdata} and events.
  logic [9:0]  out_q[$];
  int          err_cnt = 0;
  int          hdr_acc = 0;
  int          viol    = 0;
  logic [31:0] cap_dest_ip;
  logic [15:0] cap_eth_type;
  logic [7:0]  cap_ttl;

  logic [9:0]  exp_q[$];
  int          exp_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Sample at the falling edge: a beat seen here transfers at the next rise.
  always @(negedge clk) begin
    if (!rst) begin
      if (m_ip_payload_axis_tvalid && m_ip_payload_axis_tready)
        out_q.push_back({m_ip_payload_axis_tlast, m_ip_payload_axis_tuser, m_ip_payload_axis_tdata});
      if (error_payload_early_termination) err_cnt++;
      if (m_ip_hdr_valid && m_ip_hdr_ready) begin
        hdr_acc++;
        cap_dest_ip  = m_ip_dest_ip;
        cap_eth_type = m_eth_type;
        cap_ttl      = m_ip_ttl;
      end
      if (s_udp_hdr_ready && m_ip_hdr_valid) viol++;
    end
  end

  // Downstream ready generator: always-ready or random.
  always begin
    @(posedge clk);
    #1;
    if (rnd_en) begin
      m_ip_payload_axis_tready = ($urandom_range(0, 1) == 1);
      m_ip_hdr_ready           = ($urandom_range(0, 3) == 0);
    end else begin
      m_ip_payload_axis_tready = 1'b1;
      m_ip_hdr_ready           = 1'b1;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

  task automatic send_hdr(input logic [15:0] sp, input logic [15:0] dp,
                          input logic [15:0] len, input logic [15:0] cs);
    int   t  = 0;
    logic ok = 1'b0;
    s_udp_source_port = sp;
    s_udp_dest_port   = dp;
    s_udp_length      = len;
    s_udp_checksum    = cs;
    s_udp_hdr_valid   = 1'b1;
    while (!ok && t < 500) begin
      @(negedge clk);
      ok = s_udp_hdr_ready;
      @(posedge clk);
      #1;
      t++;
    end
    s_udp_hdr_valid = 1'b0;
    if (!ok) chk("hdr_accept", 32'(ok), 32'd1);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last, input logic user);
    int   t  = 0;
    logic ok = 1'b0;
    s_udp_payload_axis_tdata  = d;
    s_udp_payload_axis_tlast  = last;
    s_udp_payload_axis_tuser  = user;
    s_udp_payload_axis_tvalid = 1'b1;
    while (!ok && t < 500) begin
      @(negedge clk);
      ok = s_udp_payload_axis_tready;
      @(posedge clk);
      #1;
      t++;
    end
    s_udp_payload_axis_tvalid = 1'b0;
    if (!ok) chk("pl_accept", 32'(ok), 32'd1);
  endtask

  // Wait for n beats past base and an idle, drained DUT; then compare exp_q.
  task automatic wait_and_compare(input string tag, input int base);
    int t = 0;
    while (!((out_q.size() - base) >= exp_q.size() && !busy && !m_ip_payload_axis_tvalid)
           && t < 2000) begin
      @(posedge clk);
      #1;
      t++;
    end
    repeat (6) begin @(posedge clk); #1; end
    chk({tag, "_count"}, 32'(out_q.size() - base), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      chk($sformatf("%s_b%0d", tag, i),
          (base + i < out_q.size()) ? 32'(out_q[base + i]) : 32'hDEAD, 32'(exp_q[i]));
    end
  endtask

  // Spec-level behaviour of one frame whose last given payload byte carries tlast.
  task automatic model_frame(input logic [15:0] sp, input logic [15:0] dp,
                             input logic [15:0] len, input logic [15:0] cs,
                             input int npay, input logic user, input int k);
    logic [7:0] hb[8];
    int         rem;
    logic [7:0] d;
    hb = '{sp[15:8], sp[7:0], dp[15:8], dp[7:0], len[15:8], len[7:0], cs[15:8], cs[7:0]};
    for (int i = 0; i < 8; i++)
      exp_q.push_back({(i == 7 && len <= 16'd8), 1'b0, hb[i]});
    if (len > 16'd8) begin
      rem = int'(len) - 8;
      for (int i = 0; i < npay; i++) begin
        d = 8'(k * 16 + i);
        if (i == npay - 1) begin
          exp_q.push_back({1'b1, (rem == 1) ? user : 1'b1, d});
          if (rem != 1) exp_err++;
          break;
        end else if (rem == 1) begin
          exp_q.push_back({1'b1, user, d});
          break;
        end else begin
          exp_q.push_back({1'b0, user, d});
          rem--;
        end
      end
    end
  endtask

  int base;
  int e0;
  int h0;
  int t;
  logic [15:0] fr_len[5];
  int          fr_np[5];
  logic        fr_us[5];

  initial begin
    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hdr_ready", 32'(s_udp_hdr_ready), 32'd0);
    chk("rst_hdr_valid", 32'(m_ip_hdr_valid), 32'd0);
    chk("rst_tvalid", 32'(m_ip_payload_axis_tvalid), 32'd0);
    chk("rst_pl_tready", 32'(s_udp_payload_axis_tready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(error_payload_early_termination), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_hdr_ready", 32'(s_udp_hdr_ready), 32'd1);

    // Nominal frame: 4-byte payload matching the declared length.
    base = out_q.size(); e0 = err_cnt;
    s_ip_dest_ip = 32'hC0A8_0163; s_eth_type = 16'h0800; s_ip_ttl = 8'd77;
    send_hdr(16'h1234, 16'h5678, 16'h000C, 16'hBEEF);
    send_byte(8'h01, 1'b0, 1'b0);
    send_byte(8'h02, 1'b0, 1'b0);
    send_byte(8'h03, 1'b0, 1'b0);
    send_byte(8'h04, 1'b1, 1'b0);
    exp_q = '{10'h012, 10'h034, 10'h056, 10'h078, 10'h000, 10'h00C, 10'h0BE, 10'h0EF,
              10'h001, 10'h002, 10'h003, 10'h204};
    wait_and_compare("nominal", base);
    chk("nominal_err", 32'(err_cnt - e0), 32'd0);
    chk("pass_dest_ip", cap_dest_ip, 32'hC0A8_0163);
    chk("pass_eth_type", 32'(cap_eth_type), 32'h0800);
    chk("pass_ttl", 32'(cap_ttl), 32'd77);
    chk("nominal_busy", 32'(busy), 32'd0);
    chk("nominal_hdr_ready", 32'(s_udp_hdr_ready), 32'd1);

    // Early termination: tlast on payload byte 2 of 4 expected.
    base = out_q.size(); e0 = err_cnt;
    send_hdr(16'h1234, 16'h5678, 16'h000C, 16'hBEEF);
    send_byte(8'h01, 1'b0, 1'b0);
    send_byte(8'h02, 1'b1, 1'b0);
    exp_q = '{10'h012, 10'h034, 10'h056, 10'h078, 10'h000, 10'h00C, 10'h0BE, 10'h0EF,
              10'h001, 10'h302};
    wait_and_compare("early", base);
    chk("early_err", 32'(err_cnt - e0), 32'd1);

    // Long payload: 5 bytes offered, 2 fit the declared length.
    base = out_q.size(); e0 = err_cnt;
    send_hdr(16'h1234, 16'h5678, 16'h000A, 16'hBEEF);
    for (int i = 1; i <= 5; i++) send_byte(8'(i), (i == 5), 1'b0);
    exp_q = '{10'h012, 10'h034, 10'h056, 10'h078, 10'h000, 10'h00A, 10'h0BE, 10'h0EF,
              10'h001, 10'h202};
    wait_and_compare("long", base);
    chk("long_err", 32'(err_cnt - e0), 32'd0);
    chk("long_busy", 32'(busy), 32'd0);

    // Length 8: header only, the single payload byte is dropped.
    base = out_q.size();
    send_hdr(16'h1234, 16'h5678, 16'h0008, 16'hBEEF);
    send_byte(8'hAA, 1'b1, 1'b0);
    exp_q = '{10'h012, 10'h034, 10'h056, 10'h078, 10'h000, 10'h008, 10'h0BE, 10'h2EF};
    wait_and_compare("hdronly", base);
    chk("hdronly_busy", 32'(busy), 32'd0);

    // Back-to-back frames under random output and header backpressure.
    fr_len = '{16'd13, 16'd9, 16'd11, 16'd12, 16'd14};
    fr_np  = '{5, 1, 3, 6, 2};
    fr_us  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    base = out_q.size(); e0 = err_cnt; h0 = hdr_acc; viol = viol;
    exp_q = {}; exp_err = 0;
    for (int k = 0; k < 5; k++)
      model_frame(16'(16'hA000 + k), 16'(16'hB000 + k), fr_len[k], 16'(16'hC000 + k),
                  fr_np[k], fr_us[k], k);
    rnd_en = 1'b1;
    h0 = hdr_acc;
    t = viol;
    for (int k = 0; k < 5; k++) begin
      send_hdr(16'(16'hA000 + k), 16'(16'hB000 + k), fr_len[k], 16'(16'hC000 + k));
      for (int i = 0; i < fr_np[k]; i++)
        send_byte(8'(k * 16 + i), (i == fr_np[k] - 1), fr_us[k]);
    end
    wait_and_compare("b2b", base);
    rnd_en = 1'b0;
    repeat (20) begin @(posedge clk); #1; end
    chk("b2b_err", 32'(err_cnt - e0), 32'(exp_err));
    chk("b2b_hdr_acc", 32'(hdr_acc - h0), 32'd5);
    chk("b2b_hdr_overlap", 32'(viol - t), 32'd0);

    // Reset after the third header byte abandons the frame.
    base = out_q.size();
    send_hdr(16'hAAAA, 16'hBBBB, 16'h000C, 16'h1111);
    t = 0;
    while ((out_q.size() - base) < 3 && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("mid_bytes_before_rst", 32'((out_q.size() - base) >= 3), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mid_rst_tvalid", 32'(m_ip_payload_axis_tvalid), 32'd0);
    chk("mid_rst_hdr_valid", 32'(m_ip_hdr_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_hdr_ready", 32'(s_udp_hdr_ready), 32'd0);
    base = out_q.size();
    repeat (12) begin @(posedge clk); #1; end
    chk("mid_rst_residual", 32'(out_q.size() - base), 32'd0);

    // Next frame after reset is intact.
    base = out_q.size();
    send_hdr(16'h1234, 16'h5678, 16'h000C, 16'hBEEF);
    send_byte(8'h01, 1'b0, 1'b0);
    send_byte(8'h02, 1'b0, 1'b0);
    send_byte(8'h03, 1'b0, 1'b0);
    send_byte(8'h04, 1'b1, 1'b0);
    exp_q = '{10'h012, 10'h034, 10'h056, 10'h078, 10'h000, 10'h00C, 10'h0BE, 10'h0EF,
              10'h001, 10'h002, 10'h003, 10'h204};
    wait_and_compare("post_rst", base);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
